// File: rtl/spi_receiver.sv
// SPI mode-0 slave that assembles MSB-first bytes into commands: one opcode byte,
// followed by a 32-bit little-endian argument when the opcode MSB is set.
module spi_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic [7:0]  opcode,
    output logic [31:0] opdata,
    output logic        execute,
    output logic        abort
);

    typedef enum logic [1:0] {
        IDLE,
        READ_DATA,
        EXECUTE
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   dly_sclk;
    logic                   rise;

    logic [7:0]             shift_reg;
    logic [2:0]             bit_cnt;
    logic                   rx_strobe;

    state_t                 state;
    state_t                 next_state;
    logic [1:0]             byte_cnt;
    logic                   abort_set;

    // Presetting CS high and SCLK low keeps a reset from looking like a rising clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            dly_sclk  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            dly_sclk  <= sclk_s;
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~dly_sclk & ~cs_s;

    always_ff @(posedge clk) begin
        if (rst || cs_s) begin
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
            rx_strobe <= 1'b0;
        end else begin
            rx_strobe <= rise && (bit_cnt == 3'd7);
            if (rise) begin
                shift_reg <= {shift_reg[6:0], mosi_s};
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rx_strobe) begin
                    next_state = shift_reg[7] ? READ_DATA : EXECUTE;
                end
            end
            READ_DATA: begin
                if (rx_strobe && (byte_cnt == 2'd3)) begin
                    next_state = EXECUTE;
                end else if (cs_s) begin
                    next_state = IDLE;
                end
            end
            EXECUTE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A final argument byte landing together with CS release still completes the command.
    always_comb begin
        execute   = (state == EXECUTE);
        abort_set = (state == READ_DATA) && cs_s && !(rx_strobe && (byte_cnt == 2'd3));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opcode   <= 8'h00;
            opdata   <= 32'h0000_0000;
            byte_cnt <= 2'd0;
            abort    <= 1'b0;
        end else begin
            abort <= abort_set;
            case (state)
                IDLE: begin
                    if (rx_strobe) begin
                        opcode <= shift_reg;
                        if (shift_reg[7]) begin
                            byte_cnt <= 2'd0;
                        end
                    end
                end
                READ_DATA: begin
                    if (rx_strobe) begin
                        opdata[{byte_cnt, 3'b000} +: 8] <= shift_reg;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
